// File: rtl/lc3_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, branch
// redirect and the decode-side valid/ready queue interface.
interface lc3_fetch_unit_if;
   logic [15:0] PC;
   logic        instrmem_rd;
   logic [15:0] instr_dout;
   logic        complete_instr;
   logic        br_taken;
   logic [15:0] taddr;
   logic        dec_ready;
   logic        dec_valid;
   logic [15:0] dec_instr;
   logic [15:0] dec_npc;

   // Fetch unit side
   modport master (
      output PC, instrmem_rd, dec_valid, dec_instr, dec_npc,
      input  instr_dout, complete_instr, br_taken, taddr, dec_ready
   );

   // Memory / decode / branch-unit side
   modport slave (
      input  PC, instrmem_rd, dec_valid, dec_instr, dec_npc,
      output instr_dout, complete_instr, br_taken, taddr, dec_ready
   );
endinterface

// File: rtl/lc3_fetch_unit.sv
// LC3 instruction fetch stage. Keeps at most one memory read outstanding,
// buffers returned instructions with their NPC in a small FIFO feeding
// decode, and redirects on br_taken. A redirect that lands mid-request
// parks in DROP so the bus stays stable until the stale read completes.
module lc3_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h3000,
   parameter int          QDEPTH   = 2
) (
   input logic              clock,
   input logic              reset,
   lc3_fetch_unit_if.master bus
);

   localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(QDEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   typedef struct packed {
      logic [15:0] instr;
      logic [15:0] npc;
   } entry_t;

   state_t           state_q, state_d;
   logic [15:0]      pc_q, pc_d;
   logic             rd_q, rd_d;
   logic [15:0]      redir_q, redir_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   entry_t           mem_q [QDEPTH];
   entry_t           mem_d [QDEPTH];
   logic             dec_valid_q, dec_valid_d;
   logic [15:0]      dec_instr_q, dec_instr_d;
   logic [15:0]      dec_npc_q, dec_npc_d;

   logic             push, pop, credit;
   logic [15:0]      pc_plus1;
   entry_t           head_d;

   assign pc_plus1 = pc_q + 16'd1;

   // Queue update; a redirect flushes and discards any same-cycle push or pop.
   // Decode outputs are registered from the post-update head.
   always_comb begin
      push     = (state_q == WAIT) && bus.complete_instr && !bus.br_taken;
      pop      = dec_valid_q && bus.dec_ready && !bus.br_taken;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (bus.br_taken) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = '{instr: bus.instr_dout, npc: pc_plus1};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end
      credit      = (count_d < FULL);
      head_d      = mem_d[rd_ptr_d];
      dec_valid_d = (count_d != '0);
      dec_instr_d = dec_valid_d ? head_d.instr : 16'h0000;
      dec_npc_d   = dec_valid_d ? head_d.npc   : 16'h0000;
   end

   // Fetch FSM next-state: request issue, completion, and redirect handling.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      rd_d    = rd_q;
      redir_d = redir_q;
      case (state_q)
         IDLE: begin
            if (bus.br_taken) begin
               pc_d = bus.taddr;
            end
            state_d = credit ? WAIT : IDLE;
            rd_d    = credit;
         end
         WAIT: begin
            if (bus.complete_instr) begin
               pc_d    = bus.br_taken ? bus.taddr : pc_plus1;
               state_d = credit ? WAIT : IDLE;
               rd_d    = credit;
            end else if (bus.br_taken) begin
               // Keep PC/rd stable on the bus; remember where to go.
               redir_d = bus.taddr;
               state_d = DROP;
            end
         end
         DROP: begin
            if (bus.complete_instr) begin
               pc_d    = bus.br_taken ? bus.taddr : redir_q;
               state_d = WAIT;
               rd_d    = 1'b1;
            end else if (bus.br_taken) begin
               redir_d = bus.taddr;
            end
         end
         default: begin
            state_d = IDLE;
            rd_d    = 1'b0;
         end
      endcase
   end

   // Control state and registered outputs, with synchronous active-low reset.
   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q     <= IDLE;
         pc_q        <= RESET_PC;
         rd_q        <= 1'b0;
         count_q     <= '0;
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         dec_valid_q <= 1'b0;
         dec_instr_q <= 16'h0000;
         dec_npc_q   <= 16'h0000;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         rd_q        <= rd_d;
         count_q     <= count_d;
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         dec_valid_q <= dec_valid_d;
         dec_instr_q <= dec_instr_d;
         dec_npc_q   <= dec_npc_d;
      end
   end

   // Queue storage and redirect target; contents are qualified by count/state.
   always_ff @(posedge clock) begin
      mem_q   <= mem_d;
      redir_q <= redir_d;
   end

   assign bus.PC          = pc_q;
   assign bus.instrmem_rd = rd_q;
   assign bus.dec_valid   = dec_valid_q;
   assign bus.dec_instr   = dec_instr_q;
   assign bus.dec_npc     = dec_npc_q;

endmodule

// File: tb/tb_lc3_fetch_unit.sv
// Directed bench for lc3_fetch_unit: a behavioural model tracks expected
// PC / request state, and a scoreboard queue holds expected decode entries.
module tb_lc3_fetch_unit;
   logic clock;
   logic reset;
   lc3_fetch_unit_if bus();

   lc3_fetch_unit #(.RESET_PC(16'h3000), .QDEPTH(2)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_q[$];
   logic [15:0] exp_pc;
   logic        exp_rd;
   logic        dropping;
   logic [15:0] pend;

   task automatic chk1(input string tag, input logic got, input logic exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] got, input logic [15:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Hold reset low for one edge with idle inputs, then check reset values.
   task automatic apply_reset();
      reset              = 1'b0;
      bus.complete_instr = 1'b0;
      bus.br_taken       = 1'b0;
      bus.dec_ready      = 1'b0;
      bus.instr_dout     = 16'h0000;
      bus.taddr          = 16'h0000;
      @(posedge clock); #1;
      chk16("rst_pc", bus.PC, 16'h3000);
      chk1 ("rst_rd", bus.instrmem_rd, 1'b0);
      chk1 ("rst_dec_valid", bus.dec_valid, 1'b0);
      chk16("rst_dec_instr", bus.dec_instr, 16'h0000);
      chk16("rst_dec_npc", bus.dec_npc, 16'h0000);
      exp_q.delete();
      exp_pc   = 16'h3000;
      exp_rd   = 1'b0;
      dropping = 1'b0;
      pend     = 16'h0000;
      reset    = 1'b1;
   endtask

   // One clock: check current outputs against the model, update the model
   // for the inputs about to be applied, drive them, and advance one edge.
   task automatic cyc(input logic cmpl, input logic [15:0] data, input logic rdy,
                      input logic br, input logic [15:0] ta);
      logic [31:0] e;
      chk16("pc_model", bus.PC, exp_pc);
      chk1 ("rd_model", bus.instrmem_rd, exp_rd);
      chk1 ("dec_valid_model", bus.dec_valid, exp_q.size() != 0);
      if (bus.dec_valid && rdy && !br && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk16("pop_instr", bus.dec_instr, e[31:16]);
         chk16("pop_npc", bus.dec_npc, e[15:0]);
      end
      if (br) exp_q.delete();
      if (exp_rd) begin
         if (cmpl) begin
            if (br) exp_pc = ta;
            else if (dropping) exp_pc = pend;
            else begin
               exp_q.push_back({data, exp_pc + 16'd1});
               exp_pc = exp_pc + 16'd1;
            end
            dropping = 1'b0;
         end else if (br) begin
            dropping = 1'b1;
            pend     = ta;
         end
      end else if (br) begin
         exp_pc = ta;
      end
      exp_rd = dropping || (exp_q.size() < 2);
      bus.complete_instr = cmpl;
      bus.instr_dout     = data;
      bus.dec_ready      = rdy;
      bus.br_taken       = br;
      bus.taddr          = ta;
      @(posedge clock); #1;
      bus.complete_instr = 1'b0;
      bus.br_taken       = 1'b0;
   endtask

   initial begin
      reset              = 1'b0;
      bus.complete_instr = 1'b0;
      bus.br_taken       = 1'b0;
      bus.dec_ready      = 1'b0;
      bus.instr_dout     = 16'h0000;
      bus.taddr          = 16'h0000;
      @(posedge clock); #1;

      // Back-to-back single-cycle fetches with decode always ready
      apply_reset();
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      chk1 ("t1_first_rd", bus.instrmem_rd, 1'b1);
      cyc(1'b1, 16'hA000, 1'b1, 1'b0, 16'h0000);
      chk16("t1_npc0", bus.dec_npc, 16'h3001);
      chk16("t1_pc1", bus.PC, 16'h3001);
      cyc(1'b1, 16'hA001, 1'b1, 1'b0, 16'h0000);
      chk16("t1_npc1", bus.dec_npc, 16'h3002);
      chk16("t1_pc2", bus.PC, 16'h3002);
      cyc(1'b1, 16'hA002, 1'b1, 1'b0, 16'h0000);
      chk16("t1_npc2", bus.dec_npc, 16'h3003);
      chk1 ("t1_rd_cont", bus.instrmem_rd, 1'b1);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

      // Queue fills with decode stalled; request resumes after a pop
      apply_reset();
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 16'hB000, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 16'hB001, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 16'hB002, 1'b0, 1'b0, 16'h0000);
      chk1 ("t2_full_rd", bus.instrmem_rd, 1'b0);
      chk16("t2_full_pc", bus.PC, 16'h3002);
      chk16("t2_head_npc", bus.dec_npc, 16'h3001);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      chk1 ("t2_resume_rd", bus.instrmem_rd, 1'b1);
      chk16("t2_resume_pc", bus.PC, 16'h3002);
      chk16("t2_next_npc", bus.dec_npc, 16'h3002);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

      // Redirect mid-request with 3-cycle latency
      apply_reset();
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      cyc(1'b0, 16'h0000, 1'b1, 1'b1, 16'h4000);
      chk16("t3_pc_held", bus.PC, 16'h3000);
      chk1 ("t3_rd_held", bus.instrmem_rd, 1'b1);
      cyc(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000);
      chk16("t3_pc_target", bus.PC, 16'h4000);
      chk1 ("t3_rd_target", bus.instrmem_rd, 1'b1);
      chk1 ("t3_discard", bus.dec_valid, 1'b0);
      cyc(1'b1, 16'h1234, 1'b0, 1'b0, 16'h0000);
      chk16("t3_npc", bus.dec_npc, 16'h4001);
      chk16("t3_instr", bus.dec_instr, 16'h1234);
      // Second redirect while dropping overwrites the target
      cyc(1'b0, 16'h0000, 1'b1, 1'b1, 16'h4200);
      chk1 ("t3_flush", bus.dec_valid, 1'b0);
      cyc(1'b0, 16'h0000, 1'b1, 1'b1, 16'h4300);
      cyc(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000);
      chk16("t3_overwrite_pc", bus.PC, 16'h4300);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

      // Redirect coincident with completion
      apply_reset();
      cyc(1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000);
      cyc(1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000);
      chk16("t4_pc3001", bus.PC, 16'h3001);
      cyc(1'b1, 16'h2222, 1'b0, 1'b1, 16'h5000);
      chk16("t4_pc5000", bus.PC, 16'h5000);
      chk1 ("t4_flushed", bus.dec_valid, 1'b0);
      chk1 ("t4_rd", bus.instrmem_rd, 1'b1);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      chk1 ("t4_still_empty", bus.dec_valid, 1'b0);

      // PC wrap at FFFF
      apply_reset();
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);
      cyc(1'b1, 16'h0BAD, 1'b1, 1'b1, 16'hFFFF);
      chk16("t5_pc_ffff", bus.PC, 16'hFFFF);
      cyc(1'b1, 16'hBEEF, 1'b1, 1'b0, 16'h0000);
      chk16("t5_npc_wrap", bus.dec_npc, 16'h0000);
      chk16("t5_pc_wrap", bus.PC, 16'h0000);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

      // Reset while a request is outstanding and the queue is non-empty
      cyc(1'b1, 16'hC000, 1'b0, 1'b0, 16'h0000);
      chk1 ("t6_pre_valid", bus.dec_valid, 1'b1);
      apply_reset();
      cyc(1'b1, 16'hDEAD, 1'b1, 1'b0, 16'h0000);
      chk1 ("t6_late_ignored", bus.dec_valid, 1'b0);
      chk16("t6_pc", bus.PC, 16'h3000);
      chk1 ("t6_rd", bus.instrmem_rd, 1'b1);
      cyc(1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
